// File: rtl/tlp_rx_sequencer_if.sv
// Byte-in / result-out handshake bundle of the TLP receive sequencer.
// master = link byte source plus result consumer, slave = the sequencer.
interface tlp_rx_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sop;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [9:0]  pkt_class;
  logic [10:0] pkt_len_dw;
  logic        pkt_err;

  modport master (
    output in_valid, in_data, in_sop, pkt_ready,
    input  in_ready, pkt_valid, pkt_class, pkt_len_dw, pkt_err
  );

  modport slave (
    input  in_valid, in_data, in_sop, pkt_ready,
    output in_ready, pkt_valid, pkt_class, pkt_len_dw, pkt_err
  );
endinterface

// File: rtl/tlp_rx_sequencer.sv
// Byte-serial TLP receive sequencer: frames 3DW headers, counts payload, posts one result per packet.
// Optional per-class result statistics are compiled in with the TLP_STATS_EN macro.
module tlp_rx_sequencer #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  tlp_rx_sequencer_if.slave rx,
  output logic [7:0]        type_byte,
  input  logic [9:0]        type_class,
  input  logic [3:0]        stat_sel,
  output logic [STAT_W-1:0] stat_count
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  hdr_cnt;
  logic [9:0]  cls_q;
  logic [9:0]  len_q;
  logic [12:0] byte_cnt;

  logic        in_ready;
  logic        xfer;
  logic        hdr_last;
  logic        pay_last;
  logic        post;
  logic [9:0]  post_class;
  logic [10:0] post_len;
  logic        post_err;

  // A pending, unaccepted result blocks every byte, so no byte can post over it.
  assign in_ready    = !(rx.pkt_valid && !rx.pkt_ready);
  assign rx.in_ready = in_ready;
  assign xfer        = rx.in_valid && in_ready;
  assign hdr_last    = (hdr_cnt == 4'd11);
  assign pay_last    = (byte_cnt == 13'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (xfer) begin
      if (rx.in_sop) begin
        state_nxt = HDR;
      end else begin
        case (state)
          HDR:     if (hdr_last) state_nxt = (cls_q != '0 && type_byte[6]) ? PAYLOAD : IDLE;
          PAYLOAD: if (pay_last) state_nxt = IDLE;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // Result posting: aborts and unsupported types report err with zero length.
  always_comb begin
    post       = 1'b0;
    post_class = cls_q;
    post_len   = '0;
    post_err   = 1'b0;
    if (xfer) begin
      case (state)
        HDR: begin
          if (rx.in_sop) begin
            post     = 1'b1;
            post_err = 1'b1;
          end else if (hdr_last) begin
            if (cls_q == '0) begin
              post     = 1'b1;
              post_err = 1'b1;
            end else if (!type_byte[6]) begin
              post = 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (rx.in_sop) begin
            post     = 1'b1;
            post_err = 1'b1;
          end else if (pay_last) begin
            post     = 1'b1;
            post_len = (len_q == '0) ? 11'd1024 : {1'b0, len_q};
          end
        end
        default: post = 1'b0;
      endcase
    end
  end

  // Header capture and payload byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_byte <= '0;
      hdr_cnt   <= '0;
      cls_q     <= '0;
      len_q     <= '0;
      byte_cnt  <= '0;
    end else if (xfer) begin
      if (rx.in_sop) begin
        type_byte <= rx.in_data;
        hdr_cnt   <= 4'd1;
        cls_q     <= '0;
        len_q     <= '0;
      end else begin
        case (state)
          HDR: begin
            hdr_cnt <= hdr_cnt + 4'd1;
            case (hdr_cnt)
              4'd1:    cls_q       <= type_class;
              4'd2:    len_q[9:8]  <= rx.in_data[1:0];
              4'd3:    len_q[7:0]  <= rx.in_data;
              4'd11:   byte_cnt    <= {((len_q == '0) ? 11'd1024 : {1'b0, len_q}), 2'b00};
              default: hdr_cnt     <= hdr_cnt + 4'd1;
            endcase
          end
          PAYLOAD: byte_cnt <= byte_cnt - 13'd1;
          default: hdr_cnt  <= hdr_cnt;
        endcase
      end
    end
  end

  // Result register: a new post may replace a result that is being accepted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.pkt_valid  <= 1'b0;
      rx.pkt_class  <= '0;
      rx.pkt_len_dw <= '0;
      rx.pkt_err    <= 1'b0;
    end else if (post) begin
      rx.pkt_valid  <= 1'b1;
      rx.pkt_class  <= post_class;
      rx.pkt_len_dw <= post_len;
      rx.pkt_err    <= post_err;
    end else if (rx.pkt_ready) begin
      rx.pkt_valid  <= 1'b0;
    end
  end

`ifdef TLP_STATS_EN
  logic [STAT_W-1:0] stat_cnt [11];

  // NOTE: the counter array is reset entry by entry because its values are architecturally visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) stat_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      if (rx.pkt_valid && rx.pkt_ready) begin
        for (int i = 0; i < 10; i++) begin
          if (!rx.pkt_err && rx.pkt_class[i] && !(&stat_cnt[i]))
            stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
        end
        if (rx.pkt_err && !(&stat_cnt[10]))
          stat_cnt[10] <= stat_cnt[10] + STAT_W'(1);
      end
      stat_count <= (stat_sel <= 4'd10) ? stat_cnt[stat_sel] : '0;
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_tlp_rx_sequencer.sv
// Directed self-checking bench for tlp_rx_sequencer; the stats scenario adapts to TLP_STATS_EN.
module tb_tlp_rx_sequencer;
`ifdef TLP_STATS_EN
  localparam int STAT_W = 2;
`else
  localparam int STAT_W = 16;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        type_byte;
  logic [9:0]        type_class;
  logic [3:0]        stat_sel = 4'd0;
  logic [STAT_W-1:0] stat_count;
  int                n_checks = 0;
  int                n_fail = 0;

  tlp_rx_sequencer_if bus ();

  tlp_rx_sequencer #(.STAT_W(STAT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (bus),
    .type_byte  (type_byte),
    .type_class (type_class),
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  // Reference type decoder: MRd32 -> bit 0, IOWr -> bit 3, CplD -> bit 9, others unsupported.
  always_comb begin
    case (type_byte)
      8'h00:   type_class = 10'd1;
      8'h42:   type_class = 10'd8;
      8'h4A:   type_class = 10'd512;
      default: type_class = 10'd0;
    endcase
  end

  logic [22:0] pkt_bits;
  assign pkt_bits = {bus.pkt_valid, bus.pkt_class, bus.pkt_len_dw, bus.pkt_err};

  function automatic logic [7:0] hdr_byte(input int i, input logic [7:0] b0, input logic [9:0] len);
    case (i)
      0:       return b0;
      1:       return 8'h00;
      2:       return {6'b0, len[9:8]};
      3:       return len[7:0];
      default: return 8'(8'h10 + i);
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic sop);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sop   = sop;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard == 100) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] b0, input logic [9:0] len, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(hdr_byte(i, b0, len), i == 0);
  endtask

  task automatic send_payload(input int n);
    for (int i = 0; i < n; i++) send_byte(8'(i), 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({bus.in_ready, type_byte, pkt_bits} !== {1'b1, 8'h00, 23'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required %h", {bus.in_ready, type_byte, pkt_bits}, {1'b1, 8'h00, 23'd0});
    end
    n_checks++;
    if (stat_count !== '0) begin
      n_fail++;
      $display("FAIL reset_stat_count: got %0d, required 0", stat_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_mrd32;
    send_hdr(8'h00, 10'd1, 0, 10);
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mrd32_early: pkt_valid=%b before byte 11, required 0", bus.pkt_valid);
    end
    send_hdr(8'h00, 10'd1, 11, 11);
    n_checks++;
    if (pkt_bits !== {1'b1, 10'd1, 11'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mrd32_result: got %h, required %h", pkt_bits, {1'b1, 10'd1, 11'd0, 1'b0});
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mrd32_accept: pkt_valid=%b after accept, required 0", bus.pkt_valid);
    end
  endtask

  task automatic test_cpld;
    send_hdr(8'h4A, 10'd2, 0, 11);
    send_payload(7);
    n_checks++;
    if ({type_byte, bus.pkt_valid} !== {8'h4A, 1'b0}) begin
      n_fail++;
      $display("FAIL cpld_early: got %h, required %h", {type_byte, bus.pkt_valid}, {8'h4A, 1'b0});
    end
    send_payload(1);
    n_checks++;
    if (pkt_bits !== {1'b1, 10'd512, 11'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL cpld_result: got %h, required %h", pkt_bits, {1'b1, 10'd512, 11'd2, 1'b0});
    end
  endtask

  task automatic test_cpld_1024;
    send_hdr(8'h4A, 10'd0, 0, 11);
    send_payload(4095);
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cpld1024_early: pkt_valid=%b after 4095 bytes, required 0", bus.pkt_valid);
    end
    send_payload(1);
    n_checks++;
    if (pkt_bits !== {1'b1, 10'd512, 11'd1024, 1'b0}) begin
      n_fail++;
      $display("FAIL cpld1024_result: got %h, required %h", pkt_bits, {1'b1, 10'd512, 11'd1024, 1'b0});
    end
  endtask

  task automatic test_unsupported;
    send_hdr(8'h20, 10'd1, 0, 11);
    n_checks++;
    if (pkt_bits !== {1'b1, 10'd0, 11'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL unsup_result: got %h, required %h", pkt_bits, {1'b1, 10'd0, 11'd0, 1'b1});
    end
    // Four stray bytes would complete a 1-DW payload if the type had been treated as one.
    send_payload(4);
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL unsup_no_payload: pkt_valid=%b, required 0", bus.pkt_valid);
    end
  endtask

  task automatic test_abort_backpressure;
    send_hdr(8'h42, 10'd1, 0, 5);
    bus.pkt_ready = 1'b0;
    send_byte(8'h42, 1'b1);
    n_checks++;
    if ({bus.in_ready, pkt_bits} !== {1'b0, 1'b1, 10'd8, 11'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_result: got %h, required %h", {bus.in_ready, pkt_bits}, {1'b0, 1'b1, 10'd8, 11'd0, 1'b1});
    end
    bus.in_valid = 1'b1;
    bus.in_data  = hdr_byte(1, 8'h42, 10'd1);
    bus.in_sop   = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if ({bus.in_ready, type_byte, pkt_bits} !== {1'b0, 8'h42, 1'b1, 10'd8, 11'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_hold: got %h, required %h", {bus.in_ready, type_byte, pkt_bits}, {1'b0, 8'h42, 1'b1, 10'd8, 11'd0, 1'b1});
    end
    bus.pkt_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: pkt_valid=%b, required 0", bus.pkt_valid);
    end
    send_hdr(8'h42, 10'd1, 2, 11);
    send_payload(3);
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL iowr_early: pkt_valid=%b, required 0", bus.pkt_valid);
    end
    send_payload(1);
    n_checks++;
    if (pkt_bits !== {1'b1, 10'd8, 11'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL iowr_result: got %h, required %h", pkt_bits, {1'b1, 10'd8, 11'd1, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    send_hdr(8'h00, 10'd1, 0, 3);
    send_byte(8'h00, 1'b1);
    n_checks++;
    if (pkt_bits !== {1'b1, 10'd1, 11'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_abort1: got %h, required %h", pkt_bits, {1'b1, 10'd1, 11'd0, 1'b1});
    end
    // Accept and re-post on the same edge: the abort before byte 1 carries class 0.
    send_byte(8'h4A, 1'b1);
    n_checks++;
    if (pkt_bits !== {1'b1, 10'd0, 11'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_abort2: got %h, required %h", pkt_bits, {1'b1, 10'd0, 11'd0, 1'b1});
    end
    send_hdr(8'h4A, 10'd1, 1, 11);
    send_payload(4);
    n_checks++;
    if (pkt_bits !== {1'b1, 10'd512, 11'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_cpld: got %h, required %h", pkt_bits, {1'b1, 10'd512, 11'd1, 1'b0});
    end
  endtask

  task automatic test_reset_mid_packet;
    send_hdr(8'h4A, 10'd1, 0, 4);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, type_byte, pkt_bits} !== {1'b1, 8'h00, 23'd0}) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h, required %h", {bus.in_ready, type_byte, pkt_bits}, {1'b1, 8'h00, 23'd0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_hdr(8'h4A, 10'd1, 5, 11);
    send_payload(4);
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_result: pkt_valid=%b, required 0", bus.pkt_valid);
    end
  endtask

  task automatic test_stats;
`ifdef TLP_STATS_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) send_hdr(8'h00, 10'd1, 0, 11);
    send_hdr(8'h20, 10'd0, 0, 11);
    repeat (2) begin @(posedge clk); #1; end
    stat_sel = 4'd0;
    @(posedge clk); #1;
    n_checks++;
    if (stat_count !== 2'd3) begin
      n_fail++;
      $display("FAIL stat_sat_class0: got %0d, required 3", stat_count);
    end
    stat_sel = 4'd10;
    @(posedge clk); #1;
    n_checks++;
    if (stat_count !== 2'd1) begin
      n_fail++;
      $display("FAIL stat_err: got %0d, required 1", stat_count);
    end
    stat_sel = 4'd9;
    @(posedge clk); #1;
    n_checks++;
    if (stat_count !== 2'd0) begin
      n_fail++;
      $display("FAIL stat_class9: got %0d, required 0", stat_count);
    end
    stat_sel = 4'd15;
    @(posedge clk); #1;
    n_checks++;
    if (stat_count !== 2'd0) begin
      n_fail++;
      $display("FAIL stat_out_of_range: got %0d, required 0", stat_count);
    end
`else
    stat_sel = 4'd0;
    @(posedge clk); #1;
    n_checks++;
    if (stat_count !== '0) begin
      n_fail++;
      $display("FAIL stat_disabled: got %0d, required 0", stat_count);
    end
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sop    = 1'b0;
    bus.pkt_ready = 1'b1;
    test_reset();
    test_mrd32();
    test_cpld();
    test_cpld_1024();
    test_unsupported();
    test_abort_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
